// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave that funnels single transactions onto a simple register bus.
// One holding register per AW/W/AR channel; one transaction in flight at a time.
module axi4lite_reg_bridge #(
  parameter int          N         = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          WIN_SIZE  = 4096
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [31:0]      AWADDR,
  input  logic [2:0]       AWPROT,
  input  logic             WVALID,
  output logic             WREADY,
  input  logic [8*N-1:0]   WDATA,
  input  logic [N-1:0]     WSTRB,
  output logic             BVALID,
  input  logic             BREADY,
  output logic [1:0]       BRESP,
  input  logic             ARVALID,
  output logic             ARREADY,
  input  logic [31:0]      ARADDR,
  input  logic [2:0]       ARPROT,
  output logic             RVALID,
  input  logic             RREADY,
  output logic [8*N-1:0]   RDATA,
  output logic [1:0]       RRESP,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_write,
  output logic [31:0]      req_addr,
  output logic [8*N-1:0]   req_wdata,
  output logic [N-1:0]     req_strb,
  input  logic             rsp_valid,
  input  logic [8*N-1:0]   rsp_rdata,
  input  logic             rsp_err,
  output logic [1:0]       o_dbg_state
);
  localparam int          DW         = 8 * N;
  localparam logic [32:0] WIN_LIMIT  = 33'(WIN_SIZE);
  localparam logic [31:0] ALIGN_MASK = ~(32'(N) - 32'd1);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;
  localparam logic [1:0]  RESP_DEC   = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t          r_state, w_state_next;
  logic            r_init;
  logic            r_aw_full, r_w_full, r_ar_full;
  logic [31:0]     r_aw_addr, r_ar_addr;
  logic [DW-1:0]   r_w_data;
  logic [N-1:0]    r_w_strb;
  logic            r_last_wr, r_is_wr;
  logic [31:0]     r_addr;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic [N-1:0]    r_strb;
  logic [1:0]      r_resp;

  logic            w_aw_hs, w_w_hs, w_ar_hs;
  logic            w_wr_pend, w_rd_pend, w_launch, w_grant_wr, w_in_range;
  logic [31:0]     w_aw_addr, w_ar_addr, w_launch_addr, w_offset;
  logic [DW-1:0]   w_wdata;
  logic [N-1:0]    w_wstrb;
  logic            w_unused_prot;

  assign w_unused_prot = ^{AWPROT, ARPROT};

  // A handshake in the launch cycle counts as pending, so a transaction can
  // start in the same cycle its last channel arrives (bypassing the holding reg).
  assign w_aw_hs    = AWVALID & AWREADY;
  assign w_w_hs     = WVALID & WREADY;
  assign w_ar_hs    = ARVALID & ARREADY;
  assign w_aw_addr  = r_aw_full ? r_aw_addr : AWADDR;
  assign w_ar_addr  = r_ar_full ? r_ar_addr : ARADDR;
  assign w_wdata    = r_w_full ? r_w_data : WDATA;
  assign w_wstrb    = r_w_full ? r_w_strb : WSTRB;
  assign w_wr_pend  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_rd_pend  = r_ar_full | w_ar_hs;
  assign w_launch   = (r_state == S_IDLE) & (w_wr_pend | w_rd_pend);
  assign w_grant_wr = w_wr_pend & (~w_rd_pend | ~r_last_wr);

  assign w_launch_addr = w_grant_wr ? w_aw_addr : w_ar_addr;
  assign w_offset      = (w_launch_addr - BASE_ADDR) & ALIGN_MASK;
  assign w_in_range    = {1'b0, w_offset} < WIN_LIMIT;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_state_next = w_in_range ? S_REQ : S_RESP;
      S_REQ:  if (req_ready) w_state_next = S_WAIT;
      S_WAIT: if (rsp_valid) w_state_next = S_RESP;
      S_RESP: if ((r_is_wr & BREADY) | (~r_is_wr & RREADY)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    AWREADY     = r_init & ~r_aw_full;
    WREADY      = r_init & ~r_w_full;
    ARREADY     = r_init & ~r_ar_full;
    req_valid   = (r_state == S_REQ);
    BVALID      = (r_state == S_RESP) & r_is_wr;
    RVALID      = (r_state == S_RESP) & ~r_is_wr;
    BRESP       = r_resp;
    RRESP       = r_resp;
    RDATA       = r_rdata;
    req_write   = r_is_wr;
    req_addr    = r_addr;
    req_wdata   = r_wdata;
    req_strb    = r_strb;
    o_dbg_state = r_state;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_init    <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_aw_addr <= '0;
      r_ar_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_last_wr <= 1'b0;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
    end else begin
      r_init <= 1'b1;
      if (w_launch & w_grant_wr) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= AWADDR;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= WDATA;
          r_w_strb <= WSTRB;
        end
      end
      if (w_launch & ~w_grant_wr) begin
        r_ar_full <= 1'b0;
      end else if (w_ar_hs) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= ARADDR;
      end
      if (w_launch) begin
        r_last_wr <= w_grant_wr;
        r_is_wr   <= w_grant_wr;
        r_addr    <= w_offset;
        r_wdata   <= w_grant_wr ? w_wdata : '0;
        r_strb    <= w_grant_wr ? w_wstrb : '0;
        r_rdata   <= '0;
        r_resp    <= w_in_range ? RESP_OKAY : RESP_DEC;
      end
      if ((r_state == S_WAIT) && rsp_valid) begin
        r_resp <= rsp_err ? RESP_SLV : RESP_OKAY;
        if (!r_is_wr) r_rdata <= rsp_rdata;
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge (N=4, BASE_ADDR=0, WIN_SIZE=4096).
// Each step drives inputs 1ns after the rising edge and checks registered outputs.
module tb_axi4lite_reg_bridge;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_strb;
  logic [1:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;

  axi4lite_reg_bridge #(.N(4), .BASE_ADDR(32'h0), .WIN_SIZE(4096)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_dbg_state(o_dbg_state)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (req_valid && req_ready) req_cnt++;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept the pending request, then return one response cycle.
  task automatic serve(input logic err, input logic [31:0] data);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_err   = err;
    rsp_rdata = data;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
  endtask

  task automatic ack();
    BREADY = 1'b1;
    RREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    RREADY = 1'b0;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    AWVALID = 1'b1; AWADDR = a;
    WVALID  = 1'b1; WDATA  = d; WSTRB = s;
  endtask

  task automatic idle_axi();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    AWVALID = 0; AWADDR = 0; AWPROT = 0; WVALID = 0; WDATA = 0; WSTRB = 0;
    BREADY = 0; ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
    tick();
    tick();
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_outputs", {BVALID, RVALID, req_valid, BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    tick();
    chk("post_rst_readys", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Write 0x100, W one cycle ahead of AW
    WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    tick();
    WVALID = 1'b0;
    chk("w_held_wready", WREADY, 0);
    chk("w_only_no_req", req_valid, 0);
    AWVALID = 1'b1; AWADDR = 32'h100;
    tick();
    AWVALID = 1'b0;
    chk("wr1_req", {req_valid, req_write}, 2'b11);
    chk("wr1_addr", req_addr, 32'h100);
    chk("wr1_wdata", req_wdata, 32'hDEADBEEF);
    chk("wr1_strb", req_strb, 4'hF);
    chk("wr1_readys_back", {AWREADY, WREADY}, 2'b11);
    serve(1'b0, 32'h0);
    chk("wr1_bvalid", BVALID, 1);
    chk("wr1_bresp", BRESP, 2'b00);
    ack();
    chk("wr1_bvalid_drop", BVALID, 0);
    chk("wr1_req_count", req_cnt, 1);

    // Read 0x100, RREADY held low for three cycles
    ARVALID = 1'b1; ARADDR = 32'h100;
    tick();
    ARVALID = 1'b0;
    chk("rd1_req", {req_valid, req_write}, 2'b10);
    chk("rd1_addr", req_addr, 32'h100);
    chk("rd1_wdata_strb", {req_wdata, req_strb}, 0);
    serve(1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("rd1_rvalid_hold", RVALID, 1);
      chk("rd1_rdata_hold", RDATA, 32'hDEADBEEF);
      tick();
    end
    chk("rd1_rresp", RRESP, 2'b00);
    ack();
    chk("rd1_rvalid_drop", RVALID, 0);

    // Write and read pending together, twice
    drive_wr(32'h10, 32'h11111111, 4'h3);
    ARVALID = 1'b1; ARADDR = 32'h20;
    tick();
    idle_axi();
    chk("rr1_write_first", {req_valid, req_write}, 2'b11);
    chk("rr1_addr", req_addr, 32'h10);
    chk("rr1_strb", req_strb, 4'h3);
    chk("rr1_ar_held", ARREADY, 0);
    serve(1'b0, 32'h0);
    chk("rr1_bvalid", BVALID, 1);
    ack();
    tick();
    chk("rr2_read_second", {req_valid, req_write}, 2'b10);
    chk("rr2_addr", req_addr, 32'h20);
    drive_wr(32'h30, 32'h33333333, 4'hF);
    ARVALID = 1'b1; ARADDR = 32'h40;
    req_ready = 1'b1;
    tick();
    idle_axi();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'h22;
    tick();
    rsp_valid = 1'b0; rsp_rdata = 0;
    chk("rr2_rdata", {RVALID, RDATA}, {1'b1, 32'h22});
    chk("rr2_held_not_launched", {AWREADY, WREADY, ARREADY, req_valid}, 4'b0000);
    ack();
    tick();
    chk("rr3_write_third", {req_valid, req_write}, 2'b11);
    chk("rr3_addr", req_addr, 32'h30);
    serve(1'b0, 32'h0);
    chk("rr3_bvalid", BVALID, 1);
    ack();
    tick();
    chk("rr4_read_fourth", {req_valid, req_write}, 2'b10);
    chk("rr4_addr", req_addr, 32'h40);
    serve(1'b0, 32'h44);
    chk("rr4_rdata", RDATA, 32'h44);
    ack();
    chk("req_count_6", req_cnt, 6);

    // Out-of-range reads: just past the window and just below the base
    ARVALID = 1'b1; ARADDR = 32'h1000;
    tick();
    ARVALID = 1'b0;
    chk("oor_hi_rvalid", {RVALID, req_valid}, 2'b10);
    chk("oor_hi_rresp", RRESP, 2'b11);
    chk("oor_hi_rdata", RDATA, 0);
    ack();
    ARVALID = 1'b1; ARADDR = 32'hFFFF_FFFC;
    tick();
    ARVALID = 1'b0;
    chk("oor_lo_rvalid", {RVALID, req_valid}, 2'b10);
    chk("oor_lo_rresp", RRESP, 2'b11);
    chk("oor_lo_rdata", RDATA, 0);
    ack();
    chk("oor_no_req", req_cnt, 6);
    ARVALID = 1'b1; ARADDR = 32'hFFF;
    tick();
    ARVALID = 1'b0;
    chk("edge_in_range_req", req_valid, 1);
    chk("edge_aligned_addr", req_addr, 32'hFFC);
    serve(1'b0, 32'h55);
    chk("edge_rresp", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h55});
    ack();

    // Slave error on a write, then reset while waiting for a response
    drive_wr(32'h200, 32'hA5A5A5A5, 4'hF);
    tick();
    idle_axi();
    chk("err_req", req_valid, 1);
    serve(1'b1, 32'h0);
    chk("err_bresp", {BVALID, BRESP}, {1'b1, 2'b10});
    ack();
    drive_wr(32'h300, 32'h12345678, 4'hF);
    tick();
    idle_axi();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("abort_in_wait", o_dbg_state, 2'd2);
    ARESETn = 1'b0;
    tick();
    chk("abort_outputs", {req_valid, BVALID, AWREADY}, 3'b000);
    chk("abort_state", o_dbg_state, 2'd0);
    ARESETn = 1'b1;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("abort_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    tick();
    chk("abort_no_resp", {BVALID, RVALID, req_valid}, 3'b000);
    chk("abort_idle", o_dbg_state, 2'd0);
    drive_wr(32'h500, 32'h0, 4'h1);
    ARVALID = 1'b1; ARADDR = 32'h600;
    tick();
    idle_axi();
    chk("rst_tie_write_first", {req_valid, req_write}, 2'b11);
    chk("rst_tie_addr", req_addr, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
